// File: rtl/weight_update_ctrl.sv
// rtl/weight_update_ctrl.sv - STDP read-modify-write sweep sequencer with inference read-port priority
module weight_update_ctrl #(
    parameter int M     = 784,
    parameter int W     = 24,
    parameter int AW    = 10,
    parameter int A_POS = 64,
    parameter int A_NEG = 32,
    parameter int WMAX  = 65536,
    parameter int WMIN  = -65536
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_update,
    output logic          busy,
    output logic          done_update,
    input  logic          inf_req,
    input  logic [AW-1:0] inf_addr,
    output logic          inf_rvalid,
    output logic [AW-1:0] ram_addr_r,
    input  logic [W-1:0]  ram_data_r,
    input  logic          pre_bit,
    output logic [AW-1:0] ram_addr_w,
    output logic [W-1:0]  ram_data_w,
    output logic          ram_we
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [AW-1:0]   LAST_IDX = AW'(M - 1);
    localparam logic signed [W:0] POS_STEP = (W + 1)'(A_POS);
    localparam logic signed [W:0] NEG_STEP = (W + 1)'(A_NEG);
    localparam logic signed [W:0] MAX_X    = (W + 1)'(WMAX);
    localparam logic signed [W:0] MIN_X    = (W + 1)'(WMIN);

    state_t        state, state_nxt;
    logic [AW-1:0] idx, idx_nxt;

    logic signed [W:0] wext;
    logic signed [W:0] sum;
    logic [W-1:0]      new_w;

    // One guard bit is enough: |weight| < 2^(W-1) and the steps are small.
    always_comb begin
        wext = {ram_data_r[W-1], ram_data_r};
        sum  = pre_bit ? (wext + POS_STEP) : (wext - NEG_STEP);
        if (sum > MAX_X) begin
            new_w = MAX_X[W-1:0];
        end else if (sum < MIN_X) begin
            new_w = MIN_X[W-1:0];
        end else begin
            new_w = sum[W-1:0];
        end
    end

    // Inference always wins the read port, in every state.
    assign ram_addr_r = inf_req ? inf_addr : idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            inf_rvalid <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            inf_rvalid <= inf_req;
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        busy        = (state != IDLE);
        done_update = 1'b0;
        ram_we      = 1'b0;
        ram_addr_w  = '0;
        ram_data_w  = '0;
        case (state)
            IDLE: begin
                if (start_update) begin
                    state_nxt = RD;
                    idx_nxt   = '0;
                end
            end
            RD: begin
                if (!inf_req) begin
                    state_nxt = WB;
                end
            end
            WB: begin
                // Read data for idx is consumed here, so a grant this cycle is harmless.
                ram_we     = 1'b1;
                ram_addr_w = idx;
                ram_data_w = new_w;
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx + AW'(1);
                    state_nxt = RD;
                end
            end
            DONE: begin
                done_update = 1'b1;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_weight_update_ctrl.sv
// tb/tb_weight_update_ctrl.sv - randomized self-checking bench for weight_update_ctrl
module tb_weight_update_ctrl;

    localparam int M  = 784;
    localparam int W  = 24;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_update = 1'b0;
    logic          busy, done_update;
    logic          inf_req = 1'b0;
    logic [AW-1:0] inf_addr = '0;
    logic          inf_rvalid;
    logic [AW-1:0] ram_addr_r, ram_addr_w;
    logic [W-1:0]  rdata;
    logic          pbit;
    logic [W-1:0]  ram_data_w;
    logic          ram_we;
    logic          load = 1'b0;

    weight_update_ctrl dut (
        .clk(clk), .rst(rst), .start_update(start_update), .busy(busy),
        .done_update(done_update), .inf_req(inf_req), .inf_addr(inf_addr),
        .inf_rvalid(inf_rvalid), .ram_addr_r(ram_addr_r), .ram_data_r(rdata),
        .pre_bit(pbit), .ram_addr_w(ram_addr_w), .ram_data_w(ram_data_w), .ram_we(ram_we)
    );

    always #5 clk = ~clk;

    logic signed [W-1:0] mem    [M];
    logic signed [W-1:0] init_w [M];
    bit                  preh   [M];
    int                  expw   [M];
    int                  expc   [M];

    // Weight RAM and pre-history memory: registered read, read-before-write.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < M; i++) mem[i] <= init_w[i];
        end else if (ram_we && int'(ram_addr_w) < M) begin
            mem[ram_addr_w] <= ram_data_w;
        end
        if (int'(ram_addr_r) < M) begin
            rdata <= mem[ram_addr_r];
            pbit  <= preh[ram_addr_r];
        end else begin
            rdata <= '0;
            pbit  <= 1'b0;
        end
    end

    int   wcnt [M];
    int   wbase [M];
    int   nwr = 0, ndone = 0, nconsec = 0;
    int   nw0, nd0, nc0;
    logic prev_we = 1'b0;

    always @(negedge clk) begin
        if (ram_we) begin
            if (int'(ram_addr_w) < M) wcnt[ram_addr_w]++;
            nwr++;
            if (prev_we) nconsec++;
        end
        prev_we = ram_we;
        if (done_update) ndone++;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input int w, input bit p);
        int s;
        s = p ? w + 64 : w - 32;
        if (s > 65536) return 65536;
        if (s < -65536) return -65536;
        return s;
    endfunction

    function automatic int rand_w();
        case ($urandom_range(0, 3))
            0:       return int'($signed(24'($urandom)));
            1:       return 65536 + int'($urandom_range(0, 400)) - 200;
            2:       return -65536 + int'($urandom_range(0, 400)) - 200;
            default: return int'($urandom_range(0, 140000)) - 70000;
        endcase
    endfunction

    task automatic gen_random();
        for (int i = 0; i < M; i++) begin
            init_w[i] = 24'(rand_w());
            preh[i]   = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic build_expect(input int upto);
        for (int i = 0; i < M; i++) begin
            expw[i] = (i < upto) ? model(int'(init_w[i]), preh[i]) : int'(init_w[i]);
            expc[i] = (i < upto) ? 1 : 0;
        end
    endtask

    task automatic load_ram();
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        nd0 = ndone;
        nw0 = nwr;
        nc0 = nconsec;
        for (int i = 0; i < M; i++) wbase[i] = wcnt[i];
    endtask

    // mode: 0 plain, 1 inference hold after write 50, 2 repeat start after write 10,
    // 3 reset during read of 300, 4 inference together with start
    task automatic sweep(input int mode, input longint inf_exp, output int cyc);
        int hold;
        bit armed;
        bit fin;
        hold  = 0;
        armed = 0;
        fin   = 0;
        cyc   = 0;
        @(negedge clk);
        start_update = 1'b1;
        if (mode == 4) begin
            inf_req  = 1'b1;
            inf_addr = 10'd5;
            hold     = 3;
        end
        while (!fin && cyc < 4000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start_update = 1'b0;
            if (hold > 0) begin
                check("inf_rvalid", inf_rvalid, 1);
                check("inf_data", longint'($signed(rdata)), inf_exp);
                hold--;
                if (hold == 0) inf_req = 1'b0;
            end
            case (mode)
                1: if (!armed && ram_we && ram_addr_w == 10'd50) begin
                    armed    = 1;
                    inf_req  = 1'b1;
                    inf_addr = 10'd5;
                    hold     = 21;
                end
                2: if (!armed && ram_we && ram_addr_w == 10'd10) begin
                    armed        = 1;
                    start_update = 1'b1;
                end
                3: begin
                    if (armed) begin
                        if (rst) begin
                            check("rst_busy", busy, 0);
                            check("rst_we", ram_we, 0);
                            rst = 1'b0;
                            fin = 1;
                        end else begin
                            rst = 1'b1;
                        end
                    end else if (ram_we && ram_addr_w == 10'd299) begin
                        armed = 1;
                    end
                end
                default: ;
            endcase
            if (done_update) fin = 1;
        end
        if (!fin) check("sweep_timeout", 0, 1);
    endtask

    task automatic post_checks(input string t, input int exp_wr, input int exp_done);
        int bad_mem;
        int bad_cnt;
        bad_mem = 0;
        bad_cnt = 0;
        repeat (5) @(negedge clk);
        check({t, "_busy_after"}, busy, 0);
        check({t, "_done_pulses"}, ndone - nd0, exp_done);
        check({t, "_writes"}, nwr - nw0, exp_wr);
        check({t, "_back2back_we"}, nconsec - nc0, 0);
        for (int i = 0; i < M; i++) begin
            if (int'(mem[i]) != expw[i]) bad_mem++;
            if (wcnt[i] - wbase[i] != expc[i]) bad_cnt++;
        end
        check({t, "_ram_mismatches"}, bad_mem, 0);
        check({t, "_per_addr_write_count"}, bad_cnt, 0);
    endtask

    initial begin
        int cyc;
        int bad;
        bad = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy || done_update || inf_rvalid || ram_we || ram_addr_r != '0 ||
                ram_addr_w != '0 || ram_data_w != '0) bad++;
        end
        check("reset_idle_outputs", bad, 0);
        check("reset_no_write", nwr, 0);
        check("reset_busy", busy, 0);

        for (int i = 0; i < M; i++) begin
            init_w[i] = 24'd100;
            preh[i]   = 1'b1;
        end
        build_expect(M);
        load_ram();
        sweep(0, 0, cyc);
        check("plain_latency", cyc, 2 * M + 1);
        post_checks("plain", M, 1);
        check("plain_addr0", longint'(mem[0]), 164);
        check("plain_addr783", longint'(mem[M-1]), 164);

        gen_random();
        init_w[0] = 24'(65500);  preh[0] = 1'b1;
        init_w[1] = 24'(-65500); preh[1] = 1'b0;
        init_w[2] = 24'(-65520); preh[2] = 1'b0;
        init_w[3] = 24'(8000000);  preh[3] = 1'b0;
        init_w[4] = 24'(-8000000); preh[4] = 1'b1;
        build_expect(M);
        load_ram();
        sweep(1, longint'(expw[5]), cyc);
        check("stall_latency", cyc, 2 * M + 1 + 20);
        post_checks("stall", M, 1);
        check("sat_hi", longint'(mem[0]), 65536);
        check("near_lo", longint'(mem[1]), -65532);
        check("sat_lo", longint'(mem[2]), -65536);
        check("clamp_over", longint'(mem[3]), 65536);
        check("clamp_under", longint'(mem[4]), -65536);

        gen_random();
        build_expect(300);
        load_ram();
        sweep(3, 0, cyc);
        post_checks("midreset", 300, 0);

        gen_random();
        build_expect(M);
        load_ram();
        sweep(2, 0, cyc);
        check("restart_latency", cyc, 2 * M + 1);
        post_checks("restart", M, 1);

        gen_random();
        build_expect(M);
        load_ram();
        sweep(4, longint'(init_w[5]), cyc);
        check("start_inf_latency", cyc, 2 * M + 1 + 2);
        post_checks("start_inf", M, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/weight_update_ctrl.md
Name: weight_update_ctrl

Overview:
- Sequences the STDP read-modify-write sweep over one neuron's weight RAM: M synapses, signed W-bit entries, 1-cycle registered read, independent write port.
- Arbitrates the single RAM read port between the core's inference requester (priority) and the update sweep.
- Sits between the SNN core controller, the pre-spike history memory and the weight RAM.

Parameters:
- M, 784, number of synapses / RAM depth; index range 0..M-1
- W, 24, weight width (signed two's complement)
- AW, 10, address width
- A_POS, 64, potentiation step, added when pre-spike bit = 1
- A_NEG, 32, depression step, subtracted when pre-spike bit = 0
- WMAX, 65536, upper saturation bound (16*4096)
- WMIN, -65536, lower saturation bound (-16*4096)

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous active-high reset
- start_update  in  1  pulse; begin sweep (post-neuron fired)
- busy  out  1  high from accepted start until done
- done_update  out  1  one-cycle pulse after last write
- inf_req  in  1  inference read request (level, sampled each cycle)
- inf_addr  in  AW  inference read address
- inf_rvalid  out  1  high the cycle after a granted inf_req; ram_data_r is inference data
- ram_addr_r  out  AW  RAM read address; also drives pre-history memory address
- ram_data_r  in  W  RAM read data, valid the cycle after ram_addr_r
- pre_bit  in  1  pre-spike history bit for ram_addr_r, valid with the same 1-cycle latency
- ram_addr_w  out  AW  RAM write address
- ram_data_w  out  W  RAM write data
- ram_we  out  1  RAM write enable

Behaviour:
- Reset: state IDLE, idx=0, busy=0, done_update=0, inf_rvalid=0, ram_we=0, ram_addr_r=0, ram_addr_w=0, ram_data_w=0.
- Read-port mux: when inf_req=1, ram_addr_r=inf_addr (grant) in every state; otherwise ram_addr_r=idx. inf_rvalid <= inf_req (registered). Inference is always granted, with a fixed 1-cycle latency.
- FSM states: IDLE, RD, WB, DONE.
  - IDLE: start_update=1 -> RD, idx=0, busy=1. Otherwise stay.
  - RD: if inf_req=1, stall in RD; idx is unchanged and no update read is issued. Else issue read of idx -> WB.
  - WB: ram_data_r and pre_bit belong to idx. Compute the new weight, assert ram_we=1 with ram_addr_w=idx and ram_data_w=result for exactly this cycle. If idx=M-1 -> DONE; else idx+1 -> RD. An inf_req in WB is granted normally and does not disturb the capture, because data is consumed this cycle.
  - DONE: done_update=1 for one cycle, busy=0 next -> IDLE.
- Throughput: 2 cycles per synapse without contention, so 2*M cycles from the RD entry to the last write. Total start-to-done_update = 2*M+1 cycles.
- Arithmetic:
  - sum = sign-extended weight (W+1 bits) + A_POS if pre_bit, else - A_NEG.
  - If sum > WMAX, result = WMAX. If sum < WMIN, result = WMIN. Else result = sum[W-1:0].
  - Existing values already outside [WMIN, WMAX] are also clamped.
- Simultaneous events:
  - start_update while busy is ignored.
  - start_update and inf_req in the same cycle: the start is accepted; the first RD stalls.
  - Inference read of the address written in that same cycle returns the pre-update value (RAM read-before-write).
- Reset mid-sweep: next cycle is IDLE with ram_we=0. Partial updates remain in RAM, and no done_update pulse is generated.
- No write ever occurs outside WB; ram_we is never high for two consecutive cycles.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, ram_we never asserted.
- start_update, all pre_bit=1, all weights 100 -> each address written 164; done_update exactly 1569 cycles after start; busy low after.
- Weight 65500 with pre_bit=1 -> written 65536. Weight -65500 with pre_bit=0 -> written -65532. Weight -65520 with pre_bit=0 -> written -65536.
- Hold inf_req=1 (inf_addr=5) for 20 cycles during the sweep -> inf_rvalid every following cycle with weight[5]; sweep stalls 20 cycles; no address skipped or written twice; final RAM matches reference model.
- Assert rst when idx=300 -> IDLE next cycle; addresses 0..299 updated, 300..783 unchanged; no done_update.
- Second start_update at idx=10 -> ignored; exactly M writes and a single done_update.
